// File: rtl/bouncing_box_renderer.sv
// Pixel source: solid square that moves STEP pixels per frame and bounces off the active-area edges.
// Optional macro BOUNCE_BORDER_EN draws a white 1-pixel frame around the active area.
module bouncing_box_renderer #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned BOX_SIZE  = 32,
  parameter int unsigned STEP      = 2,
  parameter logic [7:0]  BOX_COLOR = 8'hE0,
  parameter logic [7:0]  BG_COLOR  = 8'h03
) (
  input  logic        board_clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic [10:0] h_count,
  input  logic [10:0] v_count,
  input  logic        pause,
  output logic [7:0]  rgb,
  output logic        frame_tick,
  output logic [7:0]  bounce_count
);

  localparam int unsigned CW = 11;
  localparam int unsigned EW = 12;
  localparam logic [EW-1:0] XMAX    = EW'(H_ACTIVE - BOX_SIZE);
  localparam logic [EW-1:0] YMAX    = EW'(V_ACTIVE - BOX_SIZE);
  localparam logic [EW-1:0] STEP_W  = EW'(STEP);
  localparam logic [EW-1:0] BOX_W   = EW'(BOX_SIZE);
  localparam logic [EW-1:0] H_ACT_W = EW'(H_ACTIVE);
  localparam logic [EW-1:0] V_ACT_W = EW'(V_ACTIVE);

  typedef enum logic [1:0] {ST_WAIT, ST_MOVE_X, ST_MOVE_Y} state_t;

  typedef struct packed {
    logic          bounce;
    logic          dir;
    logic [CW-1:0] pos;
  } axis_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_x, r_y, w_x_next, w_y_next;
  logic          r_dx, r_dy, w_dx_next, w_dy_next;
  logic          r_bf, w_bf_next, r_frz, w_frz_next;
  logic [7:0]    r_bounce_count, w_bounce_count_next;
  logic          r_frame_tick, w_frame_tick_next;
  logic [7:0]    r_rgb, w_rgb_next;
  logic          w_trigger;
  axis_t         w_ax, w_ay;

  // One-axis move with clamp at 0 / lim; 12-bit compare so pos+STEP never wraps.
  function automatic axis_t step_axis(input logic [CW-1:0] pos, input logic up,
                                      input logic [EW-1:0] lim);
    logic [EW-1:0] pe;
    axis_t         res;
    pe = {1'b0, pos};
    if (up) begin
      if (pe + STEP_W >= lim) res = '{bounce: 1'b1, dir: 1'b0, pos: lim[CW-1:0]};
      else                    res = '{bounce: 1'b0, dir: 1'b1, pos: CW'(pe + STEP_W)};
    end else begin
      if (pe <= STEP_W) res = '{bounce: 1'b1, dir: 1'b1, pos: '0};
      else              res = '{bounce: 1'b0, dir: 1'b0, pos: CW'(pe - STEP_W)};
    end
    return res;
  endfunction

  assign w_trigger = pix_en && (h_count == '0) && ({1'b0, v_count} == V_ACT_W);
  assign w_ax      = step_axis(r_x, r_dx, XMAX);
  assign w_ay      = step_axis(r_y, r_dy, YMAX);

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_WAIT;
      r_x            <= '0;
      r_y            <= '0;
      r_dx           <= 1'b1;
      r_dy           <= 1'b1;
      r_bf           <= 1'b0;
      r_frz          <= 1'b0;
      r_bounce_count <= '0;
      r_frame_tick   <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_x            <= w_x_next;
      r_y            <= w_y_next;
      r_dx           <= w_dx_next;
      r_dy           <= w_dy_next;
      r_bf           <= w_bf_next;
      r_frz          <= w_frz_next;
      r_bounce_count <= w_bounce_count_next;
      r_frame_tick   <= w_frame_tick_next;
    end
  end

  // Frame update: X in the cycle after the trigger, Y (and bounce tally) the cycle after that.
  always_comb begin
    w_state_next        = r_state;
    w_x_next            = r_x;
    w_y_next            = r_y;
    w_dx_next           = r_dx;
    w_dy_next           = r_dy;
    w_bf_next           = r_bf;
    w_frz_next          = r_frz;
    w_bounce_count_next = r_bounce_count;
    w_frame_tick_next   = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (w_trigger) begin
          w_state_next      = ST_MOVE_X;
          w_frame_tick_next = 1'b1;
        end
      end
      ST_MOVE_X: begin
        w_state_next = ST_MOVE_Y;
        w_frz_next   = pause;
        if (!pause) begin
          w_x_next  = w_ax.pos;
          w_dx_next = w_ax.dir;
          w_bf_next = r_bf | w_ax.bounce;
        end
      end
      ST_MOVE_Y: begin
        w_state_next = ST_WAIT;
        if (!r_frz) begin
          w_y_next  = w_ay.pos;
          w_dy_next = w_ay.dir;
        end
        if (r_bf || (!r_frz && w_ay.bounce)) w_bounce_count_next = r_bounce_count + 8'd1;
        w_bf_next = 1'b0;
      end
      default: w_state_next = ST_WAIT;
    endcase
  end

  // Pixel colour selection for the position currently presented.
  always_comb begin
    logic [EW-1:0] he, ve, xe, ye;
    he = {1'b0, h_count};
    ve = {1'b0, v_count};
    xe = {1'b0, r_x};
    ye = {1'b0, r_y};
    w_rgb_next = BG_COLOR;
    if (he >= H_ACT_W || ve >= V_ACT_W) begin
      w_rgb_next = 8'h00;
`ifdef BOUNCE_BORDER_EN
    end else if (he == '0 || he == H_ACT_W - 12'd1 || ve == '0 || ve == V_ACT_W - 12'd1) begin
      w_rgb_next = 8'hFF;
`endif
    end else if (he >= xe && he < xe + BOX_W && ve >= ye && ve < ye + BOX_W) begin
      w_rgb_next = BOX_COLOR;
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset)       r_rgb <= '0;
    else if (pix_en) r_rgb <= w_rgb_next;
  end

  assign rgb          = r_rgb;
  assign frame_tick   = r_frame_tick;
  assign bounce_count = r_bounce_count;

endmodule
